// File: rtl/i2c_slave_rx_fifo.sv
// Receive-byte FIFO between the i2c_slave core and the AXI-Lite wrapper: edge-detected push, FWFT read,
// sticky overflow and a registered irq. Optional level-threshold irq enabled by I2C_RXFIFO_LEVEL_IRQ_EN.
module i2c_slave_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int DW    = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] i2c_rx_data,
    input  logic          i2c_data_valid,
    input  logic          flush,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level,
    output logic          overflow,
    input  logic          ovf_clr,
    input  logic [AW:0]   irq_thresh,
    output logic          irq
);

    logic [DW-1:0] mem [DEPTH];

    logic [AW:0] wptr_reg, wptr_next;
    logic [AW:0] rptr_reg, rptr_next;
    logic        dv_q_reg;
    logic        overflow_reg, overflow_next;
    logic        irq_reg, irq_next;
    logic [AW:0] level_next;

    logic push_ev;
    logic pop;
    logic push_ok;
    logic ovf_set;

    assign empty = (wptr_reg == rptr_reg);
    assign full  = (wptr_reg[AW] != rptr_reg[AW]) && (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);
    assign level = wptr_reg - rptr_reg;

    // One push per rising edge of the core's data_valid level.
    assign push_ev = i2c_data_valid && !dv_q_reg;
    assign pop     = rd_en && !empty;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the byte.
    assign push_ok = push_ev && (!full || pop) && !flush;
    assign ovf_set = push_ev && full && !pop && !flush;

    always_comb begin
        wptr_next     = wptr_reg;
        rptr_next     = rptr_reg;
        overflow_next = ovf_set || (overflow_reg && !ovf_clr);
        if (flush) begin
            wptr_next = '0;
            rptr_next = '0;
        end else begin
            wptr_next = wptr_reg + {{AW{1'b0}}, push_ok};
            rptr_next = rptr_reg + {{AW{1'b0}}, pop};
        end
        level_next = wptr_next - rptr_next;
    end

`ifdef I2C_RXFIFO_LEVEL_IRQ_EN
    logic [AW:0] thresh_eff;

    assign thresh_eff = (irq_thresh == '0) ? {{AW{1'b0}}, 1'b1} : irq_thresh;
    assign irq_next   = (level_next >= thresh_eff) || overflow_next;
`else
    logic unused_irq_thresh;

    assign unused_irq_thresh = ^irq_thresh;
    assign irq_next          = (level_next != '0) || overflow_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            dv_q_reg     <= 1'b1;
            overflow_reg <= 1'b0;
            irq_reg      <= 1'b0;
        end else begin
            wptr_reg     <= wptr_next;
            rptr_reg     <= rptr_next;
            dv_q_reg     <= i2c_data_valid;
            overflow_reg <= overflow_next;
            irq_reg      <= irq_next;
        end
    end

    // Storage is not reset; pointers alone define the valid contents.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr_reg[AW-1:0]] <= i2c_rx_data;
        end
    end

    assign rd_data  = empty ? '0 : mem[rptr_reg[AW-1:0]];
    assign overflow = overflow_reg;
    assign irq      = irq_reg;

endmodule
